// File: rtl/eda_pkg.sv
// rtl/eda_pkg.sv - shared neighbour indices and push-stack FSM states
package eda_pkg;

    localparam int NB_UPLEFT    = 0;
    localparam int NB_UP        = 1;
    localparam int NB_UPRIGHT   = 2;
    localparam int NB_LEFT      = 3;
    localparam int NB_RIGHT     = 4;
    localparam int NB_DOWNLEFT  = 5;
    localparam int NB_DOWN      = 6;
    localparam int NB_DOWNRIGHT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

endpackage

// File: rtl/eda_push_stack_if.sv
// rtl/eda_push_stack_if.sv - load/pop/status bundle of the push stack
interface eda_push_stack_if #(
    parameter int NB = 8,
    parameter int AW = 8,
    parameter int CW = 9
);
    logic             clear;
    logic             load;
    logic [NB-1:0]    push_mask;
    logic [NB*AW-1:0] neigh_addr;
    logic             busy;
    logic             pop;
    logic [AW-1:0]    top_addr;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output clear, load, push_mask, neigh_addr, pop,
        input  busy, top_addr, empty, full, count, overflow
    );

    modport slave (
        input  clear, load, push_mask, neigh_addr, pop,
        output busy, top_addr, empty, full, count, overflow
    );
endinterface

// File: rtl/eda_lowest_set_finder.sv
// rtl/eda_lowest_set_finder.sv - index of the lowest set bit plus a valid flag
module eda_lowest_set_finder #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  i_bits,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Scan downward so the last hit, the lowest index, wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = W - 1; k >= 0; k--) begin
            if (i_bits[k]) begin
                o_idx   = IW'(k);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eda_push_stack.sv
// rtl/eda_push_stack.sv - serialises a neighbour push mask into a LIFO address stack
module eda_push_stack
    import eda_pkg::*;
#(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M * N),
    parameter int DEPTH        = M * N
) (
    input  logic              clk,
    input  logic              reset_n,
    eda_push_stack_if.slave   bus
);

    localparam int NB = WINDOW_WIDTH - 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (NB > 1) ? $clog2(NB) : 1;

    state_t                   r_state;
    logic [NB-1:0]            r_mask;
    logic [NB*ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]            r_count;
    logic                     r_overflow;
    logic [ADDR_WIDTH-1:0]    r_mem [DEPTH];

    logic [SW-1:0]            w_sel;
    logic                     w_sel_valid;
    logic [NB-1:0]            w_mask_next;
    logic [ADDR_WIDTH-1:0]    w_push_addr;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_empty;
    logic                     w_full;
    logic [IW-1:0]            w_top_idx;
    logic [IW-1:0]            w_wr_idx;

    eda_lowest_set_finder #(
        .W  (NB),
        .IW (SW)
    ) u_finder (
        .i_bits  (r_mask),
        .o_idx   (w_sel),
        .o_valid (w_sel_valid)
    );

    assign w_mask_next = r_mask & ~(NB'(1) << w_sel);
    assign w_push_addr = r_addr[int'(w_sel) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_push      = (r_state == PUSH) && w_sel_valid;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_pop       = bus.pop && !w_empty;
    assign w_top_idx   = IW'(r_count - CW'(1));
    // A concurrent pop frees the top slot, so the push overwrites it in place.
    assign w_wr_idx    = w_pop ? w_top_idx : IW'(r_count);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.load && (bus.push_mask != '0)) begin
                        r_mask  <= bus.push_mask;
                        r_addr  <= bus.neigh_addr;
                        r_state <= PUSH;
                    end
                end
                PUSH: begin
                    r_mask <= w_mask_next;
                    if (w_mask_next == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_push && !w_pop) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!bus.clear && w_push && (w_pop || !w_full)) begin
            r_mem[w_wr_idx] <= w_push_addr;
        end
    end

    assign bus.busy     = (r_state == PUSH);
    assign bus.top_addr = r_mem[w_top_idx];
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.count    = r_count;
    assign bus.overflow = r_overflow;

endmodule
